// File: rtl/segre_pkg.sv
// Shared types for the segre core: ALU opcodes (including the M extension),
// memory access sizes, execute-slot states and opcode classification helpers.
package segre_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_LUI,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_opcode_e;

  typedef enum logic [1:0] {
    MEM_BYTE, MEM_HALF, MEM_WORD
  } memop_data_type_e;

  typedef enum logic [1:0] {
    EMPTY, ALU_RDY, MD_BUSY, MD_RDY
  } ex_state_e;

  function automatic logic is_md_op(input alu_opcode_e op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_div_op(input alu_opcode_e op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/segre_alu.sv
// Single-cycle integer ALU; branch opcodes produce the PC-relative target.
module segre_alu
  import segre_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  alu_opcode_e          alu_opcode_i,
  input  logic [WORD_SIZE-1:0] alu_src_a_i,
  input  logic [WORD_SIZE-1:0] alu_src_b_i,
  output logic [WORD_SIZE-1:0] alu_res_o
);

  localparam int SH_W = $clog2(WORD_SIZE);

  logic [SH_W-1:0] shamt;
  assign shamt = alu_src_b_i[SH_W-1:0];

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    alu_res_o = '0;
    case (alu_opcode_i)
      ALU_ADD, ALU_BEQ, ALU_BNE, ALU_BLT,
      ALU_BGE, ALU_BLTU, ALU_BGEU: alu_res_o = alu_src_a_i + alu_src_b_i;
      ALU_SUB:  alu_res_o = alu_src_a_i - alu_src_b_i;
      ALU_AND:  alu_res_o = alu_src_a_i & alu_src_b_i;
      ALU_OR:   alu_res_o = alu_src_a_i | alu_src_b_i;
      ALU_XOR:  alu_res_o = alu_src_a_i ^ alu_src_b_i;
      ALU_SLL:  alu_res_o = alu_src_a_i << shamt;
      ALU_SRL:  alu_res_o = alu_src_a_i >> shamt;
      ALU_SRA:  alu_res_o = $unsigned($signed(alu_src_a_i) >>> shamt);
      ALU_SLT:  alu_res_o = {{(WORD_SIZE-1){1'b0}}, $signed(alu_src_a_i) < $signed(alu_src_b_i)};
      ALU_SLTU: alu_res_o = {{(WORD_SIZE-1){1'b0}}, alu_src_a_i < alu_src_b_i};
      ALU_LUI:  alu_res_o = alu_src_b_i;
      default:  alu_res_o = '0;
    endcase
  end

endmodule

// File: rtl/segre_mdu.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider
// on operand magnitudes, sharing one adder per resolved bit.
module segre_mdu
  import segre_pkg::*;
#(
  parameter int WORD_SIZE         = 32,
  parameter int MD_BITS_PER_CYCLE = 1
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 start_i,
  input  logic                 kill_i,
  input  alu_opcode_e          op_i,
  input  logic [WORD_SIZE-1:0] src_a_i,
  input  logic [WORD_SIZE-1:0] src_b_i,
  output logic                 special_o,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] result_o
);

  localparam int W      = WORD_SIZE;
  localparam int N_ITER = WORD_SIZE / MD_BITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(N_ITER + 1);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic           signed_op, div_op, a_neg, b_neg, div_zero, div_ovf;
  logic [W-1:0]   a_mag, b_mag, special_res;

  alu_opcode_e    op_q;
  logic           sign_x_q, sign_r_q, busy_q, mul_q;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   dvs_q, res_q;
  logic [CNT_W-1:0] cnt_q;

  logic [W:0]     add_a, add_b;
  logic [W+1:0]   add_sum;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, final_res;

  assign signed_op = op_i inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  assign div_op    = is_div_op(op_i);
  assign a_neg     = signed_op & src_a_i[W-1];
  assign b_neg     = signed_op & src_b_i[W-1];
  assign a_mag     = a_neg ? -src_a_i : src_a_i;
  assign b_mag     = b_neg ? -src_b_i : src_b_i;
  assign div_zero  = div_op & (src_b_i == '0);
  assign div_ovf   = (op_i inside {ALU_DIV, ALU_REM}) & (src_a_i == MIN_VAL) & (&src_b_i);
  assign special_o = div_zero | div_ovf;

  // Results that need no iteration are known the moment the op arrives.
  always_comb begin
    special_res = '0;
    if (div_zero)             special_res = (op_i inside {ALU_DIV, ALU_DIVU}) ? '1 : src_a_i;
    else if (op_i == ALU_DIV) special_res = MIN_VAL;
  end

  assign mul_q = !is_div_op(op_q);

  // acc holds {product high, multiplier} or {partial remainder, quotient}.
  always_comb begin
    acc_d   = acc_q;
    add_a   = '0;
    add_b   = '0;
    add_sum = '0;
    for (int i = 0; i < MD_BITS_PER_CYCLE; i++) begin
      if (mul_q) begin
        add_a = {1'b0, acc_d[2*W-1:W]};
        add_b = acc_d[0] ? {1'b0, dvs_q} : '0;
      end else begin
        add_a = {acc_d[2*W-1:W], acc_d[W-1]};
        add_b = ~{1'b0, dvs_q};
      end
      add_sum = {1'b0, add_a} + {1'b0, add_b} + (W+2)'(!mul_q);
      if (mul_q)             acc_d = {add_sum[W:0], acc_d[W-1:1]};
      else if (add_sum[W+1]) acc_d = {add_sum[W-1:0], acc_d[W-2:0], 1'b1};
      else                   acc_d = {add_a[W-1:0], acc_d[W-2:0], 1'b0};
    end
  end

  always_comb begin
    prod = sign_x_q ? -acc_d : acc_d;
    quo  = sign_x_q ? -acc_d[W-1:0] : acc_d[W-1:0];
    rem  = sign_r_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
    case (op_q)
      ALU_MUL:             final_res = prod[W-1:0];
      ALU_MULH, ALU_MULHU: final_res = prod[2*W-1:W];
      ALU_DIV, ALU_DIVU:   final_res = quo;
      default:             final_res = rem;
    endcase
  end

  assign done_o   = busy_q & (cnt_q == CNT_W'(N_ITER - 1));
  assign result_o = res_q;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      op_q     <= ALU_ADD;
      sign_x_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
    end else if (start_i) begin
      op_q     <= op_i;
      sign_x_q <= a_neg ^ b_neg;
      sign_r_q <= a_neg;
      busy_q   <= !special_o;
      cnt_q    <= '0;
      res_q    <= special_res;
      acc_q    <= {{W{1'b0}}, div_op ? a_mag : b_mag};
      dvs_q    <= div_op ? b_mag : a_mag;
    end else if (kill_i) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) begin
        busy_q <= 1'b0;
        res_q  <= final_res;
      end
    end
  end

endmodule

// File: rtl/segre_tkbr.sv
// Taken-branch decision: compares the branch operands for conditional
// branches; jumps are always taken.
module segre_tkbr
  import segre_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  alu_opcode_e          alu_opcode_i,
  input  logic                 is_jaljalr_i,
  input  logic [WORD_SIZE-1:0] br_src_a_i,
  input  logic [WORD_SIZE-1:0] br_src_b_i,
  output logic                 tkbr_o
);

  always_comb begin
    tkbr_o = is_jaljalr_i;
    case (alu_opcode_i)
      ALU_BEQ:  tkbr_o = (br_src_a_i == br_src_b_i);
      ALU_BNE:  tkbr_o = (br_src_a_i != br_src_b_i);
      ALU_BLT:  tkbr_o = ($signed(br_src_a_i) < $signed(br_src_b_i));
      ALU_BGE:  tkbr_o = ($signed(br_src_a_i) >= $signed(br_src_b_i));
      ALU_BLTU: tkbr_o = (br_src_a_i < br_src_b_i);
      ALU_BGEU: tkbr_o = (br_src_a_i >= br_src_b_i);
      default:  ;
    endcase
  end

endmodule

// File: rtl/segre_ex_mc_stage.sv
// Execute stage with a decoupled one-entry slot: single-cycle ALU results and
// iterative M-extension results, valid/ready on both sides, redirect at handoff.
module segre_ex_mc_stage
  import segre_pkg::*;
#(
  parameter int WORD_SIZE         = 32,
  parameter int REG_SIZE          = 5,
  parameter int ADDR_SIZE         = 32,
  parameter int MD_BITS_PER_CYCLE = 1
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  alu_opcode_e          alu_opcode_i,
  input  logic [WORD_SIZE-1:0] alu_src_a_i,
  input  logic [WORD_SIZE-1:0] alu_src_b_i,
  input  logic [WORD_SIZE-1:0] br_src_a_i,
  input  logic [WORD_SIZE-1:0] br_src_b_i,
  input  logic [ADDR_SIZE-1:0] pc_i,
  input  logic                 is_jaljalr_i,
  input  logic                 rf_we_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  input  memop_data_type_e     memop_type_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WORD_SIZE-1:0] alu_res_o,
  output logic [ADDR_SIZE-1:0] seq_new_pc_o,
  output logic [ADDR_SIZE-1:0] new_pc_o,
  output logic                 tkbr_o,
  output logic                 is_jaljalr_o,
  output logic                 rf_we_o,
  output logic                 memop_rd_o,
  output logic                 memop_wr_o,
  output logic                 memop_sign_ext_o,
  output memop_data_type_e     memop_type_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_st_data_o
);

  ex_state_e            state_q, state_d;
  alu_opcode_e          opcode_q;
  logic [WORD_SIZE-1:0] alu_a_q, alu_b_q, br_a_q, br_b_q, st_data_q;
  logic [ADDR_SIZE-1:0] seq_pc_q;
  logic                 is_jaljalr_q, rf_we_q, memop_rd_q, memop_wr_q, memop_sign_ext_q;
  memop_data_type_e     memop_type_q;
  logic [REG_SIZE-1:0]  rf_waddr_q;

  logic                 accept, handoff, md_start, md_special, md_done, taken;
  logic [WORD_SIZE-1:0] alu_res, md_res;

  assign valid_o  = (state_q == ALU_RDY) | (state_q == MD_RDY);
  assign handoff  = valid_o & ready_i;
  assign ready_o  = rsn_i & !flush_i & ((state_q == EMPTY) | handoff);
  assign accept   = valid_i & ready_o;
  assign md_start = accept & is_md_op(alu_opcode_i);

  segre_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .alu_opcode_i (opcode_q),
    .alu_src_a_i  (alu_a_q),
    .alu_src_b_i  (alu_b_q),
    .alu_res_o    (alu_res)
  );

  segre_tkbr #(.WORD_SIZE(WORD_SIZE)) u_tkbr (
    .alu_opcode_i (opcode_q),
    .is_jaljalr_i (is_jaljalr_q),
    .br_src_a_i   (br_a_q),
    .br_src_b_i   (br_b_q),
    .tkbr_o       (taken)
  );

  segre_mdu #(
    .WORD_SIZE         (WORD_SIZE),
    .MD_BITS_PER_CYCLE (MD_BITS_PER_CYCLE)
  ) u_mdu (
    .clk_i     (clk_i),
    .rsn_i     (rsn_i),
    .start_i   (md_start),
    .kill_i    (flush_i),
    .op_i      (alu_opcode_i),
    .src_a_i   (alu_src_a_i),
    .src_b_i   (alu_src_b_i),
    .special_o (md_special),
    .done_o    (md_done),
    .result_o  (md_res)
  );

  // Flush wins over everything; an accept replaces a result leaving this cycle.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (accept) begin
      if (!is_md_op(alu_opcode_i)) state_d = ALU_RDY;
      else if (md_special)         state_d = MD_RDY;
      else                         state_d = MD_BUSY;
    end else if (handoff) begin
      state_d = EMPTY;
    end else if ((state_q == MD_BUSY) && md_done) begin
      state_d = MD_RDY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Datapath registers are reset too so every output reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      opcode_q         <= ALU_ADD;
      alu_a_q          <= '0;
      alu_b_q          <= '0;
      br_a_q           <= '0;
      br_b_q           <= '0;
      seq_pc_q         <= '0;
      is_jaljalr_q     <= 1'b0;
      rf_we_q          <= 1'b0;
      memop_rd_q       <= 1'b0;
      memop_wr_q       <= 1'b0;
      memop_sign_ext_q <= 1'b0;
      memop_type_q     <= MEM_BYTE;
      rf_waddr_q       <= '0;
      st_data_q        <= '0;
    end else if (accept) begin
      opcode_q         <= alu_opcode_i;
      alu_a_q          <= alu_src_a_i;
      alu_b_q          <= alu_src_b_i;
      br_a_q           <= br_src_a_i;
      br_b_q           <= br_src_b_i;
      seq_pc_q         <= pc_i + ADDR_SIZE'(4);
      is_jaljalr_q     <= is_jaljalr_i;
      rf_we_q          <= rf_we_i;
      memop_rd_q       <= memop_rd_i;
      memop_wr_q       <= memop_wr_i;
      memop_sign_ext_q <= memop_sign_ext_i;
      memop_type_q     <= memop_type_i;
      rf_waddr_q       <= rf_waddr_i;
      st_data_q        <= rf_st_data_i;
    end
  end

  always_comb begin
    if (is_jaljalr_q)           alu_res_o = br_a_q;
    else if (is_md_op(opcode_q)) alu_res_o = md_res;
    else                         alu_res_o = alu_res;
  end

  assign new_pc_o         = ADDR_SIZE'(alu_res);
  assign seq_new_pc_o     = seq_pc_q;
  assign tkbr_o           = handoff & !flush_i & taken;
  assign is_jaljalr_o     = is_jaljalr_q;
  assign rf_we_o          = rf_we_q;
  assign memop_rd_o       = memop_rd_q;
  assign memop_wr_o       = memop_wr_q;
  assign memop_sign_ext_o = memop_sign_ext_q;
  assign memop_type_o     = memop_type_q;
  assign rf_waddr_o       = rf_waddr_q;
  assign rf_st_data_o     = st_data_q;

endmodule

// File: tb/tb_segre_ex_mc_stage.sv
// Directed bench for segre_ex_mc_stage: a 1-bit/cycle instance and a
// 4-bits/cycle instance sharing data inputs, each with its own handshake.
module tb_segre_ex_mc_stage;
  import segre_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rsn, valid_i, valid_i4, ready_i, ready_i4, flush_i;
  alu_opcode_e      op;
  logic [31:0]      alu_a, alu_b, br_a, br_b, pc, st_data;
  logic             is_jj, rf_we, mrd, mwr, msx;
  memop_data_type_e mtype;
  logic [4:0]       waddr;

  logic             ready_o, valid_o, tkbr, is_jj_o, rf_we_o, mrd_o, mwr_o, msx_o;
  logic [31:0]      alu_res, seq_pc, new_pc, st_data_o;
  memop_data_type_e mtype_o;
  logic [4:0]       waddr_o;

  logic             ready_o4, valid_o4, tkbr4, is_jj_o4, rf_we_o4, mrd_o4, mwr_o4, msx_o4;
  logic [31:0]      alu_res4, seq_pc4, new_pc4, st_data_o4;
  memop_data_type_e mtype_o4;
  logic [4:0]       waddr_o4;

  int n_vec = 0;
  int n_err = 0;
  int bad;

  segre_ex_mc_stage dut (
    .clk_i(clk), .rsn_i(rsn), .valid_i(valid_i), .ready_o(ready_o),
    .alu_opcode_i(op), .alu_src_a_i(alu_a), .alu_src_b_i(alu_b),
    .br_src_a_i(br_a), .br_src_b_i(br_b), .pc_i(pc),
    .is_jaljalr_i(is_jj), .rf_we_i(rf_we), .memop_rd_i(mrd), .memop_wr_i(mwr),
    .memop_sign_ext_i(msx), .memop_type_i(mtype), .rf_waddr_i(waddr),
    .rf_st_data_i(st_data), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .alu_res_o(alu_res), .seq_new_pc_o(seq_pc), .new_pc_o(new_pc), .tkbr_o(tkbr),
    .is_jaljalr_o(is_jj_o), .rf_we_o(rf_we_o), .memop_rd_o(mrd_o), .memop_wr_o(mwr_o),
    .memop_sign_ext_o(msx_o), .memop_type_o(mtype_o), .rf_waddr_o(waddr_o),
    .rf_st_data_o(st_data_o)
  );

  segre_ex_mc_stage #(.MD_BITS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rsn_i(rsn), .valid_i(valid_i4), .ready_o(ready_o4),
    .alu_opcode_i(op), .alu_src_a_i(alu_a), .alu_src_b_i(alu_b),
    .br_src_a_i(br_a), .br_src_b_i(br_b), .pc_i(pc),
    .is_jaljalr_i(is_jj), .rf_we_i(rf_we), .memop_rd_i(mrd), .memop_wr_i(mwr),
    .memop_sign_ext_i(msx), .memop_type_i(mtype), .rf_waddr_i(waddr),
    .rf_st_data_i(st_data), .flush_i(flush_i), .valid_o(valid_o4), .ready_i(ready_i4),
    .alu_res_o(alu_res4), .seq_new_pc_o(seq_pc4), .new_pc_o(new_pc4), .tkbr_o(tkbr4),
    .is_jaljalr_o(is_jj_o4), .rf_we_o(rf_we_o4), .memop_rd_o(mrd_o4), .memop_wr_o(mwr_o4),
    .memop_sign_ext_o(msx_o4), .memop_type_o(mtype_o4), .rf_waddr_o(waddr_o4),
    .rf_st_data_o(st_data_o4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one M op, wait for its result (bounded), check latency and value, hand it off.
  task automatic run_md(input logic sel4, input alu_opcode_e o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input string tag);
    int k;
    int busy_rdy;
    op    = o;
    alu_a = a;
    alu_b = b;
    if (sel4) valid_i4 = 1'b1;
    else      valid_i  = 1'b1;
    step();
    valid_i  = 1'b0;
    valid_i4 = 1'b0;
    k        = 0;
    busy_rdy = 0;
    while (!(sel4 ? valid_o4 : valid_o) && k < 100) begin
      if (sel4 ? ready_o4 : ready_o) busy_rdy++;
      step();
      k++;
    end
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_res"}, sel4 ? alu_res4 : alu_res, exp_res);
    check({tag, "_busy_rdy"}, busy_rdy, 0);
    step();
  endtask

  initial begin
    rsn = 1'b0; valid_i = 1'b0; valid_i4 = 1'b0; ready_i = 1'b1; ready_i4 = 1'b1;
    flush_i = 1'b0; op = ALU_ADD; alu_a = '0; alu_b = '0; br_a = '0; br_b = '0;
    pc = '0; st_data = '0; is_jj = 1'b0; rf_we = 1'b0; mrd = 1'b0; mwr = 1'b0;
    msx = 1'b0; mtype = MEM_WORD; waddr = '0;
    #1;
    check("rst_ready", 32'(ready_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_tkbr", 32'(tkbr), 0);
    repeat (2) @(posedge clk);
    #1;
    rsn = 1'b1;
    #1;
    check("post_rst_ready", 32'(ready_o), 1);
    check("post_rst_res", alu_res, 0);
    check("post_rst_seq", seq_pc, 0);

    // back-to-back ADDs
    op = ALU_ADD; alu_a = 3; alu_b = 4; pc = 32'h100; waddr = 5; rf_we = 1'b1; valid_i = 1'b1;
    step();
    check("add1_valid", 32'(valid_o), 1);
    check("add1_res", alu_res, 7);
    check("add1_ready", 32'(ready_o), 1);
    check("add1_waddr", 32'(waddr_o), 5);
    check("add1_we", 32'(rf_we_o), 1);
    check("add1_seq", seq_pc, 32'h104);
    alu_a = 10; alu_b = 32'hFFFF_FFFE; pc = 32'hFFFF_FFFC; waddr = 6;
    step();
    check("add2_valid", 32'(valid_o), 1);
    check("add2_res", alu_res, 8);
    check("add2_seq_wrap", seq_pc, 0);
    check("add2_waddr", 32'(waddr_o), 6);
    valid_i = 1'b0; rf_we = 1'b0;
    step();
    check("add_drain", 32'(valid_o), 0);

    // multiply/divide, 1 bit per cycle
    run_md(1'b0, ALU_DIV,   32'hFFFF_FFF9, 2,            32, 32'hFFFF_FFFD, "div_m7_2");
    run_md(1'b0, ALU_REM,   32'hFFFF_FFF9, 2,            32, 32'hFFFF_FFFF, "rem_m7_2");
    run_md(1'b0, ALU_DIVU,  5,             0,             0, 32'hFFFF_FFFF, "divu_by0");
    run_md(1'b0, ALU_REM,   5,             0,             0, 32'h0000_0005, "rem_by0");
    run_md(1'b0, ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, "div_ovf");
    run_md(1'b0, ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, "rem_ovf");
    run_md(1'b0, ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0000, "mulh_m1");
    run_md(1'b0, ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, "mulhu_ff");
    run_md(1'b0, ALU_MUL,   6,             32'hFFFF_FFF9, 32, 32'hFFFF_FFD6, "mul_6_m7");
    run_md(1'b0, ALU_DIVU,  100,           7,             32, 32'd14,        "divu_100_7");

    // multiply/divide, 4 bits per cycle
    run_md(1'b1, ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, 32'hFFFF_FFFE, "mulhu4");
    run_md(1'b1, ALU_DIV,   32'hFFFF_FFF9, 2,             8, 32'hFFFF_FFFD, "div4");
    run_md(1'b1, ALU_REMU,  100,           7,             8, 32'd2,         "remu4");

    // taken BEQ held by ready_i low for 3 cycles
    op = ALU_BEQ; alu_a = 32'h1000; alu_b = 32'h20; br_a = 9; br_b = 9;
    ready_i = 1'b0; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    bad = 0;
    repeat (3) begin
      if (tkbr || !valid_o) bad++;
      step();
    end
    check("beq_hold", bad, 0);
    check("beq_hold_res", alu_res, 32'h1020);
    ready_i = 1'b1;
    #1;
    check("beq_pulse", 32'(tkbr), 1);
    check("beq_target", new_pc, 32'h1020);
    step();
    check("beq_after", 32'(tkbr), 0);
    check("beq_after_valid", 32'(valid_o), 0);

    // not-taken BNE
    op = ALU_BNE; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    check("bne_valid", 32'(valid_o), 1);
    check("bne_tkbr", 32'(tkbr), 0);
    step();

    // JAL: link value on alu_res_o, target on new_pc_o
    op = ALU_ADD; is_jj = 1'b1; alu_a = 32'h300; alu_b = 32'h40; br_a = 32'h204; valid_i = 1'b1;
    step();
    valid_i = 1'b0; is_jj = 1'b0;
    check("jal_link", alu_res, 32'h204);
    check("jal_tkbr", 32'(tkbr), 1);
    check("jal_target", new_pc, 32'h340);
    check("jal_flag", 32'(is_jj_o), 1);
    step();

    // flush suppresses the redirect of a held taken branch
    op = ALU_BEQ; br_a = 1; br_b = 1; ready_i = 1'b0; valid_i = 1'b1;
    step();
    valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b1;
    #1;
    check("flush_tkbr", 32'(tkbr), 0);
    check("flush_ready", 32'(ready_o), 0);
    step();
    flush_i = 1'b0;
    check("flush_br_gone", 32'(valid_o), 0);

    // flush at iteration 10 of a DIVU; ADD presented alongside is dropped
    op = ALU_DIVU; alu_a = 100; alu_b = 3; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (10) step();
    flush_i = 1'b1; op = ALU_ADD; alu_a = 1; alu_b = 1; valid_i = 1'b1;
    #1;
    check("flush_md_ready", 32'(ready_o), 0);
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    bad = 0;
    repeat (40) begin
      if (valid_o) bad++;
      step();
    end
    check("flush_md_no_valid", bad, 0);
    alu_a = 1; alu_b = 2; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    check("post_flush_valid", 32'(valid_o), 1);
    check("post_flush_add", alu_res, 3);
    step();

    // reset in the middle of a MUL
    op = ALU_MUL; alu_a = 32'h1234; alu_b = 32'h10; rf_we = 1'b1; waddr = 7;
    st_data = 32'hDEAD; mwr = 1'b1; pc = 32'h400; valid_i = 1'b1;
    step();
    valid_i = 1'b0; rf_we = 1'b0; mwr = 1'b0; waddr = 0; st_data = 0;
    repeat (5) step();
    rsn = 1'b0;
    #1;
    check("rst_mid_valid", 32'(valid_o), 0);
    check("rst_mid_ready", 32'(ready_o), 0);
    check("rst_mid_res", alu_res, 0);
    check("rst_mid_we", 32'(rf_we_o), 0);
    check("rst_mid_wr", 32'(mwr_o), 0);
    check("rst_mid_waddr", 32'(waddr_o), 0);
    check("rst_mid_stdata", st_data_o, 0);
    check("rst_mid_seq", seq_pc, 0);
    check("rst_mid_newpc", new_pc, 0);
    step();
    rsn = 1'b1;
    bad = 0;
    repeat (40) begin
      if (valid_o) bad++;
      step();
    end
    check("rst_mid_no_result", bad, 0);
    check("rst_mid_ready_back", 32'(ready_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
